// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg: shared types for the M-stage memory request scheduler.
//   state_e   : scheduler FSM states
//   src_e     : which requester owns the outstanding request
//   req_t     : holding-register contents for the one outstanding request
//   SIZE_LINE : size code for a full 16B line (forced on bus requests)
package mem_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT     = 3'd2,
    ST_TLB_WAIT = 3'd3,
    ST_FAULT    = 3'd4
  } state_e;

  typedef enum logic {
    SRC_PIPE = 1'b0,
    SRC_BUS  = 1'b1
  } src_e;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic [1:0]   size;
    logic         r;
    logic         w;
    logic         sw;
    src_e         src;
  } req_t;

  localparam logic [1:0] SIZE_LINE = 2'b11;

endpackage

// File: rtl/mem_sched_pick.sv
// mem_sched_pick: combinational winner select between pipe and bus.
//   Default build: bus always beats pipe.
//   MEM_SCHED_FAIRNESS_EN defined: a saturating streak counter tracks bus
//   grants made while the pipe was waiting; once it reaches BUS_STREAK_MAX
//   the pipe wins the next grant, which clears the streak.
// Ports:
//   clk, rst       clock, async active-high reset (streak counter only)
//   grant_en_i     a grant is actually taken this cycle
//   pipe_valid_i   pipe requester valid
//   bus_valid_i    bus requester valid
//   win_pipe_o     pipe is the winner this cycle
//   win_bus_o      bus is the winner this cycle
module mem_sched_pick #(
  parameter int BUS_STREAK_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_en_i,
  input  logic pipe_valid_i,
  input  logic bus_valid_i,
  output logic win_pipe_o,
  output logic win_bus_o
);

`ifdef MEM_SCHED_FAIRNESS_EN
  localparam int SW = $clog2(BUS_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(BUS_STREAK_MAX);

  logic [SW-1:0] streak_q, streak_d;
  logic          pipe_turn;

  assign pipe_turn  = pipe_valid_i && (streak_q == STREAK_MAX);
  assign win_pipe_o = pipe_valid_i && (pipe_turn || !bus_valid_i);
  assign win_bus_o  = bus_valid_i && !pipe_turn;

  // Only bus grants that made the pipe wait count toward the streak.
  always_comb begin
    streak_d = streak_q;
    if (grant_en_i) begin
      if (win_pipe_o)
        streak_d = '0;
      else if (win_bus_o && pipe_valid_i && (streak_q != STREAK_MAX))
        streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) streak_q <= '0;
    else     streak_q <= streak_d;
  end
`else
  assign win_bus_o  = bus_valid_i;
  assign win_pipe_o = pipe_valid_i && !bus_valid_i;

  logic unused_pick;
  assign unused_pick = ^{clk, rst, grant_en_i};
`endif

endmodule

// File: rtl/mem_req_sched.sv
// mem_req_sched: front-end scheduler for the M-stage IA/AS + TLB path.
// Arbitrates pipe vs bus, issues one request at a time into IA/AS,
// sequences TLB-miss replay and protection faults, and pulses done to
// the requester that won.
// Optional feature macro: MEM_SCHED_FAIRNESS_EN (bus streak fairness).
// Ports:
//   clk, rst                       clock, async active-high reset
//   pipe_valid/pipe_ready          pipe handshake (ready only in IDLE)
//   pipe_addr/data/size/r/w/sw     pipe request fields
//   bus_valid/bus_ready            bus handshake (ready only in IDLE)
//   bus_addr/data/r/w              bus request fields
//   ia_*                           IA/AS inputs, driven from holding reg
//   ia_TLB_hit/miss, ia_prot_exc   translation result, sampled in ISSUE
//   tlb_fill_done, cache_done      completion pulses from TLB / cache
//   pipe_done/bus_done             1-cycle done pulse to the winner
//   pipe_fault                     1-cycle fault pulse to the pipe
module mem_req_sched
  import mem_sched_pkg::*;
#(
  parameter int BUS_STREAK_MAX = 3,
  parameter int TLB_REPLAY_MAX = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pipe_valid,
  output logic         pipe_ready,
  input  logic [31:0]  pipe_addr,
  input  logic [127:0] pipe_data,
  input  logic [1:0]   pipe_size,
  input  logic         pipe_r,
  input  logic         pipe_w,
  input  logic         pipe_sw,
  input  logic         bus_valid,
  output logic         bus_ready,
  input  logic [31:0]  bus_addr,
  input  logic [127:0] bus_data,
  input  logic         bus_r,
  input  logic         bus_w,
  output logic [31:0]  ia_address,
  output logic [127:0] ia_data,
  output logic [1:0]   ia_size,
  output logic         ia_r,
  output logic         ia_w,
  output logic         ia_sw,
  output logic         ia_valid,
  output logic         ia_fromBUS,
  output logic         ia_sizeOVR,
  output logic         ia_PTC_ID,
  input  logic         ia_TLB_hit,
  input  logic         ia_TLB_miss,
  input  logic         ia_prot_exc,
  input  logic         tlb_fill_done,
  input  logic         cache_done,
  output logic         pipe_done,
  output logic         bus_done,
  output logic         pipe_fault
);

  localparam int RW = $clog2(TLB_REPLAY_MAX + 1);
  localparam logic [RW-1:0] REPLAY_MAX = RW'(TLB_REPLAY_MAX);

  state_e        state_q, state_d;
  req_t          hold_q, hold_d;
  logic          tag_q, tag_d;
  logic [RW-1:0] replay_q, replay_d;
  logic          pipe_done_q, pipe_done_d;
  logic          bus_done_q, bus_done_d;

  logic grant_en, win_pipe, win_bus;

  // Readies are combinational in IDLE; gating with rst keeps every output
  // low while reset is held.
  assign grant_en = (state_q == ST_IDLE) && !rst;

  mem_sched_pick #(
    .BUS_STREAK_MAX (BUS_STREAK_MAX)
  ) u_pick (
    .clk          (clk),
    .rst          (rst),
    .grant_en_i   (grant_en),
    .pipe_valid_i (pipe_valid),
    .bus_valid_i  (bus_valid),
    .win_pipe_o   (win_pipe),
    .win_bus_o    (win_bus)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    tag_d       = tag_q;
    replay_d    = replay_q;
    pipe_done_d = 1'b0;
    bus_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_en && win_bus) begin
          hold_d   = '{addr: bus_addr, data: bus_data, size: SIZE_LINE,
                       r: bus_r, w: bus_w, sw: 1'b0, src: SRC_BUS};
          tag_d    = ~tag_q;
          replay_d = '0;
          state_d  = ST_ISSUE;
        end else if (grant_en && win_pipe) begin
          hold_d   = '{addr: pipe_addr, data: pipe_data, size: pipe_size,
                       r: pipe_r, w: pipe_w, sw: pipe_sw, src: SRC_PIPE};
          tag_d    = ~tag_q;
          replay_d = '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Bus addresses are physical, so translation results are ignored.
        // A missing hit/miss indication is treated as a miss: replaying is
        // always safe, assuming a hit is not.
        if (hold_q.src == SRC_BUS)              state_d = ST_WAIT;
        else if (ia_prot_exc)                   state_d = ST_FAULT;
        else if (ia_TLB_miss || !ia_TLB_hit)    state_d = ST_TLB_WAIT;
        else                                    state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cache_done) begin
          pipe_done_d = (hold_q.src == SRC_PIPE);
          bus_done_d  = (hold_q.src == SRC_BUS);
          state_d     = ST_IDLE;
        end
      end
      ST_TLB_WAIT: begin
        if (tlb_fill_done) begin
          replay_d = replay_q + 1'b1;
          state_d  = (replay_d == REPLAY_MAX) ? ST_FAULT : ST_ISSUE;
        end
      end
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      tag_q       <= 1'b0;
      replay_q    <= '0;
      pipe_done_q <= 1'b0;
      bus_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      tag_q       <= tag_d;
      replay_q    <= replay_d;
      pipe_done_q <= pipe_done_d;
      bus_done_q  <= bus_done_d;
    end
  end

  assign pipe_ready = grant_en && win_pipe;
  assign bus_ready  = grant_en && win_bus;

  assign ia_valid   = (state_q == ST_ISSUE);
  assign ia_address = hold_q.addr;
  assign ia_data    = hold_q.data;
  assign ia_size    = hold_q.size;
  assign ia_r       = hold_q.r;
  assign ia_w       = hold_q.w;
  assign ia_sw      = hold_q.sw;
  assign ia_fromBUS = (hold_q.src == SRC_BUS);
  assign ia_sizeOVR = (hold_q.src == SRC_BUS);
  assign ia_PTC_ID  = tag_q;

  assign pipe_done  = pipe_done_q;
  assign bus_done   = bus_done_q;
  assign pipe_fault = (state_q == ST_FAULT);

endmodule
